// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS-subset pipeline: opcode/funct
// encodings, the ALU operation enum and the pipeline-register layouts.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;      // 1: second operand is the immediate
      alu_op_e     alu_op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [31:0] pc4;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
   } id_ex_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [4:0]  dst;
      logic [31:0] alu_res;
      logic [31:0] store_data;
   } ex_mem_t;

   typedef struct packed {
      logic        reg_write;
      logic [4:0]  dst;
      logic [31:0] wdata;
   } mem_wb_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU: add, sub, and, or, signed slt, plus zero flag.
module cpu_alu
   import cpu_pkg::*;
(
   input  alu_op_e     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        zero
);

   // Operation select; beq uses ALU_SUB and looks only at the zero flag.
   always_comb begin
      // NOTE: y gets a default first so every path assigns it and no latch is inferred.
      y = '0;
      unique case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
         default: y = '0;
      endcase
   end

   assign zero = (y == 32'd0);

endmodule

// File: rtl/pipelined_cpu.sv
// Five-stage MIPS-subset pipeline with program-load port, full forwarding,
// one-cycle load-use stall and two-cycle taken-branch flush.
module pipelined_cpu
   import cpu_pkg::*;
#(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        LoadInstructions,
   input  logic [31:0] Instruction,
   output logic [31:0] out
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0]    imem [IMEM_WORDS];
   logic [31:0]    rf   [32];
   logic [31:0]    dmem [DMEM_WORDS];
   logic [IAW-1:0] load_ptr_q, load_ptr_d;

   logic [31:0] pc_q, pc_d;
   if_id_t      ifid_q, ifid_d;
   id_ex_t      idex_q, idex_d, id_dec;
   ex_mem_t     exmem_q, exmem_d;
   mem_wb_t     memwb_q, memwb_d;

   logic [31:0] instr_f, pc4_f;
   logic [4:0]  rs_id, rt_id, rd_id;
   logic        stall, taken, alu_zero, wb_we;
   logic [31:0] op_a, op_b_reg, alu_b, alu_y, br_target, mem_wdata;

   // ---------------- IF ----------------
   assign instr_f = imem[pc_q[IAW+1:2]];
   assign pc4_f   = pc_q + 32'd4;

   // ---------------- ID ----------------
   assign rs_id = ifid_q.instr[25:21];
   assign rt_id = ifid_q.instr[20:16];
   assign rd_id = ifid_q.instr[15:11];
   assign wb_we = memwb_q.reg_write && (memwb_q.dst != 5'd0);

   // Register read with same-cycle write-back bypass; $0 is hard-wired to 0.
   function automatic logic [31:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0)                  return '0;
      else if (wb_we && memwb_q.dst == idx) return memwb_q.wdata;
      else                              return rf[idx];
   endfunction

   // Instruction decode into ID/EX control and operands.
   always_comb begin
      id_dec        = '0;
      id_dec.rs     = rs_id;
      id_dec.rt     = rt_id;
      id_dec.pc4    = ifid_q.pc4;
      id_dec.rs_val = rf_read(rs_id);
      id_dec.rt_val = rf_read(rt_id);
      id_dec.imm    = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
      unique case (ifid_q.instr[31:26])
         OP_RTYPE: begin
            id_dec.dst       = rd_id;
            id_dec.reg_write = 1'b1;
            unique case (ifid_q.instr[5:0])
               FN_ADD:  id_dec.alu_op = ALU_ADD;
               FN_SUB:  id_dec.alu_op = ALU_SUB;
               FN_AND:  id_dec.alu_op = ALU_AND;
               FN_OR:   id_dec.alu_op = ALU_OR;
               FN_SLT:  id_dec.alu_op = ALU_SLT;
               // sll by 0 copies rt; rs is 0 in that encoding so OR does it.
               FN_SLL:  begin
                  id_dec.alu_op    = ALU_OR;
                  id_dec.reg_write = (ifid_q.instr[10:6] == 5'd0);
               end
               default: id_dec.reg_write = 1'b0;
            endcase
         end
         OP_ADDI: begin
            id_dec.dst       = rt_id;
            id_dec.reg_write = 1'b1;
            id_dec.alu_src   = 1'b1;
         end
         OP_LW: begin
            id_dec.dst       = rt_id;
            id_dec.reg_write = 1'b1;
            id_dec.mem_read  = 1'b1;
            id_dec.alu_src   = 1'b1;
         end
         OP_SW: begin
            id_dec.mem_write = 1'b1;
            id_dec.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            id_dec.branch = 1'b1;
            id_dec.alu_op = ALU_SUB;
         end
         default: id_dec.reg_write = 1'b0;
      endcase
   end

   assign stall = idex_q.mem_read && (idex_q.dst != 5'd0) &&
                  ((idex_q.dst == rs_id) || (idex_q.dst == rt_id));

   // ---------------- EX ----------------
   // Operand forwarding: EX/MEM beats MEM/WB beats the ID-stage register value.
   always_comb begin
      op_a = idex_q.rs_val;
      if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rs)
         op_a = exmem_q.alu_res;
      else if (wb_we && memwb_q.dst == idex_q.rs)
         op_a = memwb_q.wdata;

      op_b_reg = idex_q.rt_val;
      if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rt)
         op_b_reg = exmem_q.alu_res;
      else if (wb_we && memwb_q.dst == idex_q.rt)
         op_b_reg = memwb_q.wdata;
   end

   assign alu_b = idex_q.alu_src ? idex_q.imm : op_b_reg;

   cpu_alu u_alu (
      .op   (idex_q.alu_op),
      .a    (op_a),
      .b    (alu_b),
      .y    (alu_y),
      .zero (alu_zero)
   );

   assign taken     = idex_q.branch && alu_zero;
   assign br_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};

   // ---------------- MEM ----------------
   assign mem_wdata = exmem_q.mem_read ? dmem[exmem_q.alu_res[DAW+1:2]] : exmem_q.alu_res;

   // ---------------- WB ----------------
   assign out = wb_we ? memwb_q.wdata : 32'd0;

   // Next-state for PC and pipeline registers: branch flush, then stall, then advance.
   always_comb begin
      pc_d   = pc4_f;
      ifid_d = '{pc4: pc4_f, instr: instr_f};
      idex_d = id_dec;
      if (taken) begin
         pc_d   = br_target;
         ifid_d = '0;
         idex_d = '0;
      end else if (stall) begin
         pc_d   = pc_q;
         ifid_d = ifid_q;
         idex_d = '0;
      end

      exmem_d            = '0;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.dst        = idex_q.dst;
      exmem_d.alu_res    = alu_y;
      exmem_d.store_data = op_b_reg;

      memwb_d           = '0;
      memwb_d.reg_write = exmem_q.reg_write;
      memwb_d.dst       = exmem_q.dst;
      memwb_d.wdata     = mem_wdata;

      load_ptr_d = LoadInstructions ? load_ptr_q + 1'b1 : load_ptr_q;
   end

   // PC and pipeline registers; load mode holds the pipeline in its reset state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (Reset || LoadInstructions) begin
         pc_q    <= '0;
         ifid_q  <= '0;
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   // Program load pointer.
   always_ff @(posedge clk) begin
      if (Reset) load_ptr_q <= '0;
      else       load_ptr_q <= load_ptr_d;
   end

   // Instruction memory write port; Reset blocks loading.
   always_ff @(posedge clk) begin
      // NOTE: imem carries no reset so the program survives Reset; rf and dmem are reset explicitly.
      if (!Reset && LoadInstructions) imem[load_ptr_q] <= Instruction;
   end

   // Register file: cleared on reset, written from WB ($0 writes dropped).
   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (!LoadInstructions && wb_we) begin
         rf[memwb_q.dst] <= memwb_q.wdata;
      end
   end

   // Data memory: word k resets to 4k so a load from address A returns A.
   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int k = 0; k < DMEM_WORDS; k++) dmem[k] <= 32'(k * 4);
      end else if (!LoadInstructions && exmem_q.mem_write) begin
         dmem[exmem_q.alu_res[DAW+1:2]] <= exmem_q.store_data;
      end
   end

endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu: loads a short program exercising
// forwarding, load-use stall, store, branch flush and mid-run reset,
// then checks the write-back stream on out edge by edge.
module tb_pipelined_cpu;

   logic        clk = 1'b0;
   logic        Reset;
   logic        LoadInstructions;
   logic [31:0] Instruction;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog    [64];
   logic [31:0] exp_out [1:22];

   pipelined_cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
      .clk              (clk),
      .Reset            (Reset),
      .LoadInstructions (LoadInstructions),
      .Instruction      (Instruction),
      .out              (out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                         input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Steps n edges after reset release, comparing out against the table.
   task automatic run_checks(input string tag, input int n);
      for (int e = 1; e <= n; e++) begin
         step();
         check($sformatf("%s_edge%0d", tag, e), out, exp_out[e]);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) prog[i] = 32'd0;
      prog[0]  = enc_i(6'b001000, 0, 1, 423);      // addi R1,R0,423
      prog[1]  = enc_i(6'b001000, 0, 2, 92);       // addi R2,R0,92
      prog[2]  = enc_i(6'b001000, 0, 3, 13);       // addi R3,R0,13
      prog[3]  = enc_i(6'b001000, 0, 4, 146);      // addi R4,R0,146
      prog[4]  = enc_i(6'b001000, 0, 5, 5);        // addi R5,R0,5
      prog[5]  = enc_r(1, 4, 5, 6'b100000);        // add  R5,R1,R4 -> 569
      prog[6]  = enc_r(3, 5, 6, 6'b101010);        // slt  R6,R3,R5 -> 1
      prog[7]  = enc_i(6'b100011, 0, 4, 4);        // lw   R4,4(R0) -> 4
      prog[8]  = enc_r(4, 6, 7, 6'b100010);        // sub  R7,R4,R6 -> 3
      prog[9]  = enc_i(6'b101011, 0, 7, 0);        // sw   R7,0(R0)
      prog[10] = enc_i(6'b100011, 0, 8, 0);        // lw   R8,0(R0) -> 3
      prog[11] = enc_i(6'b000100, 0, 0, 1);        // beq  R0,R0,+1
      prog[12] = enc_i(6'b001000, 0, 9, 7);        // addi R9,R0,7 (flushed)
      prog[13] = enc_i(6'b001000, 0, 10, 9);       // addi R10,R0,9
      prog[14] = enc_r(9, 10, 11, 6'b100000);      // add  R11,R9,R10 -> 9

      // Edge-by-edge write-back values after reset release.
      exp_out[1]  = 0;   exp_out[2]  = 0;   exp_out[3]  = 0;
      exp_out[4]  = 423; exp_out[5]  = 92;  exp_out[6]  = 13;
      exp_out[7]  = 146; exp_out[8]  = 5;   exp_out[9]  = 569;
      exp_out[10] = 1;   exp_out[11] = 4;   exp_out[12] = 0;   // load-use bubble
      exp_out[13] = 3;   exp_out[14] = 0;   exp_out[15] = 3;   // sw, then lw R8
      exp_out[16] = 0;   exp_out[17] = 0;   exp_out[18] = 0;   // beq + two flushed slots
      exp_out[19] = 9;   exp_out[20] = 9;   exp_out[21] = 0;
      exp_out[22] = 0;

      Reset = 1'b1; LoadInstructions = 1'b0; Instruction = '0;
      step();
      step();
      check("reset_out", out, 32'd0);

      Reset = 1'b0; LoadInstructions = 1'b1;
      for (int n = 0; n < 64; n++) begin
         Instruction = prog[n];
         step();
      end
      check("load_hold_out", out, 32'd0);

      LoadInstructions = 1'b0; Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("run_reset_out", out, 32'd0);
      run_checks("run1", 22);

      // Restart, then interrupt mid-program with Reset and a conflicting load.
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      run_checks("run2", 9);
      Reset = 1'b1; LoadInstructions = 1'b1;
      Instruction = enc_i(6'b001000, 0, 1, 999);
      step();
      Reset = 1'b0; LoadInstructions = 1'b0; Instruction = '0;
      check("midrun_reset_out", out, 32'd0);
      run_checks("run3", 22);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_cpu.md
# pipelined_cpu

Five-stage pipelined MIPS-subset processor (IF, ID, EX, MEM, WB) with an on-chip instruction memory, register file and data memory. It sits at the top of the design. A program is first streamed in one word per clock through a load port. After a reset, the program runs and every write-back value appears on `out`. It provides full forwarding, a one-cycle load-use stall and branch flushing.

## Interface
- `IMEM_WORDS`, 64: instruction memory depth in words.
- `DMEM_WORDS`, 64: data memory depth in words.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `LoadInstructions`  in  1: program-load enable.
- `Instruction`  in  32: instruction word to store while loading.
- `out`  out  32: write-back data of the instruction in WB.

## Operation
- **Reset:**
  - PC, all pipeline registers, register file and load pointer go to 0.
  - Data memory word k is reinitialised to 4k, so a load from byte address A returns A.
  - Instruction memory is NOT cleared.
- **Load mode (`LoadInstructions`=1, `Reset`=0):**
  - Each edge writes `Instruction` to `imem[load_ptr]`, then increments `load_ptr`.
  - The pipeline is held in its reset state: no register or data-memory writes.
- **Run mode (both inputs 0):**
  - Fetch `imem[PC[7:2]]`.
  - PC advances by 4 each cycle unless stalled or redirected.
  - Unwritten instruction memory reads 0, which executes as a NOP.
- **Supported instructions:**
  - R-type (opcode 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), sll-by-0/NOP.
  - addi 001000, sign-extended immediate.
  - lw 100011 and sw 101011; address = rs + sext(imm), word index = addr[7:2].
  - beq 000100.
- **Register $0** always reads 0; writes to it are discarded.
- **Register file** is write-before-read: a WB write is visible to the ID read in the same cycle.
- **Forwarding:**
  - EX operands take EX/MEM, then MEM/WB, then the register value, in that priority.
  - Forwarding applies only when the source stage writes a nonzero rd/rt.
  - The sw store data is forwarded the same way.
- **Load-use hazard:** if the EX instruction is lw and its rt equals the ID instruction's rs or rt (nonzero), then for one cycle:
  - PC and IF/ID hold;
  - a bubble is inserted into ID/EX.
- **beq:**
  - Resolved in EX; target = PC+4 + (sext(imm)<<2).
  - When taken, the IF/ID and ID/EX contents are flushed (2-cycle penalty).
  - Not-taken predicted.
- **Output:** `out` = MEM/WB write data when RegWrite and rd≠0, else 0. It is combinational from the MEM/WB register.
- All arithmetic is 32-bit two's complement; overflow is ignored and does not trap.

## Timing
- Load: word n is written on the n-th rising edge with `LoadInstructions`=1 after reset.
- After the reset edge and the release of `Reset`, instruction i (absent stalls or flushes) is in WB after rising edge 4+i.
  - Its value is on `out` from that edge until the next one.
  - Its register write commits on edge 5+i.
- A load-use stall delays all later instructions by 1 cycle, and `out` shows 0 for the bubble.
- A taken beq delays the target by 2 cycles beyond sequential flow.
- `Reset` asserted mid-run takes effect at the next edge: pipeline emptied, `out`=0 on the following cycle, program restarts from PC 0.
- Simultaneous `Reset` and `LoadInstructions`: `Reset` wins; no memory write occurs.

## Structure
- Shared package `cpu_pkg`: opcode and funct constants, ALU-op enum, pipeline-register struct typedefs (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sub-module `cpu_alu`: a combinational 32-bit ALU for add/sub/and/or/slt, with a zero flag.
- Forwarding, hazard, register-file and memory logic live in `pipelined_cpu`.

## Test plan
- **Basic run:** load addi R1=423, R2=92, R3=13, R4=146, R5=5, then reset and run.
  - `out` = 423, 92, 13, 146, 5 on edges 4-8 after reset release.
- **Forwarding chain:** append add R5,R1,R4 then slt R6,R3,R5.
  - `out` = 569, then 1 (EX/MEM forwarding).
  - A result of 423 or 0 means forwarding is broken.
- **Load-use:** append lw R4,4(R0) then sub R7,R4,R6.
  - `out` = 4, then 0 (bubble), then 3.
  - A result of 146 or 145 means the stall or forwarding is broken.
- **Store:** append sw R7,0(R0).
  - `out` = 0 during its WB.
  - A later lw R8,0(R0) yields 3.
- **Branch:** beq R0,R0,+1 followed by addi R9,R0,7 and addi R10,R0,9.
  - R9's write is flushed (never seen on `out`); `out` later shows 9.
- **Reset mid-run:** assert `Reset` for one edge during execution.
  - `out`=0, then the program replays from PC 0 with identical values.
  - Instruction memory is retained.
